generate_mine_array: RTL
========================

// Module: generate_mine_array
// PURPOSE
//  Upstream stage of generate_num_array. On a start pulse it randomly places a
//  fixed number of mines into the board of the selected level. It never places a
//  mine on the first-clicked field. Results go out on mine_arr_easy/medium/hard,
//  indexed [x][y]. Encoding is active-low: '0' = mine, '1' = free. The consumer
//  counts cleared bits.
// PARAMETERS
//  MINES_EASY    10       mines on 8x8 board (level 1)
//  MINES_MEDIUM  16       mines on 10x10 board (level 2)
//  MINES_HARD    40       mines on 16x16 board (level 3)
//  LFSR_SEED     16'hACE1 LFSR reset value; a value of 0 is replaced by 16'h0001
// PORTS
//  clk              in   1          system clock
//  rst_n            in   1          async active-low reset
//  level            in   2          0 = no game, 1/2/3 = easy/medium/hard
//  start            in   1          1-cycle pulse: generate a board for level
//  first_x          in   5          x of first-clicked field, sampled on start
//  first_y          in   5          y of first-clicked field, sampled on start
//  mine_arr_easy    out  [7:0][7:0]   easy mine map, '0' = mine
//  mine_arr_medium  out  [9:0][9:0]   medium mine map
//  mine_arr_hard    out  [15:0][15:0] hard mine map
//  ready            out  1          board complete; held until next start or level==0
//  placed           out  6          mines placed so far on current board
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all three arrays '1 (no mines), ready=0, placed=0
//   - state IDLE, LFSR=LFSR_SEED
//  LFSR: 16-bit Galois, taps 16'hB400. Advances every clk in every state except reset.
//   - candidate cx = lfsr[4:0], cy = lfsr[9:5]
//  Size N and mine target M come from the level latched on start (8/10/16; M per param).
//  FSM states:
//   IDLE:
//    - start && level!=0 -> CLEAR; latch level, first_x, first_y
//    - start while level==0 is ignored
//   CLEAR (1 cycle):
//    - all three arrays <= '1; placed <= 0; ready <= 0 -> PICK
//   PICK (1 candidate/cycle):
//    - accept iff cx<N, cy<N, field not already '0', and field not excluded
//    - accept -> array[cx][cy] <= 0, placed <= placed+1
//    - when the accepted mine makes placed==M -> DONE
//   DONE:
//    - ready=1 (first asserted the cycle after the last write); arrays held
//    - start && level!=0 -> CLEAR (regenerate)
//  Latency:
//   - 2 cycles minimum from start to first write
//   - completes within 65535 PICK cycles, since the LFSR period covers every (cx,cy)
//  Boundaries:
//   - start during CLEAR/PICK is ignored
//   - level change vs the latched level while in PICK or DONE -> IDLE:
//     arrays '1, ready=0, placed=0
//   - level==0 in any state -> IDLE, same clearing
//   - first_x/first_y outside the board excludes nothing extra
//   - rst_n asserted mid-PICK clears immediately; no partial board survives
//  Arrays of non-selected levels always stay '1.
// CONFIGURATION
//  MINE_SAFE_ZONE_EN defined:
//   - the excluded set is the 3x3 neighbourhood of (first_x,first_y), clipped at edges
//   - the first click therefore always opens a zero-count field
//  MINE_SAFE_ZONE_EN undefined:
//   - only the single field (first_x,first_y) is excluded
//  Mine targets fit in both builds (max 40 <= 256-9).
// TESTING
//  - Reset, then release; level=1 -> arrays all '1, ready=0, placed=0
//  - level=1, start, first=(3,4) -> ready within 65540 cycles
//    - exactly 10 zeros in mine_arr_easy, all at x,y<8, [3][4]=1
//    - medium and hard arrays stay all '1
//  - level=3, start, first=(0,0) -> exactly 40 zeros in hard, [0][0]=1
//    - with MINE_SAFE_ZONE_EN: [0..1][0..1] also =1
//  - level=2, start, then start again at placed=5 -> 2nd start ignored
//    - board completes with placed=16, exactly 16 zeros
//  - level=2 board in progress, level forced to 0 -> next cycle: IDLE, ready=0, all arrays '1
//  - level=1 board at ready=1, second start with first=(7,7) -> one cycle CLEAR (all '1)
//    - then a new board with 10 mines and [7][7]=1

Source files
------------

// File: rtl/generate_mine_array.sv
// Random mine placement for the selected board, sparing the first-clicked field.
// Build option: define MINE_SAFE_ZONE_EN to also spare the 3x3 neighbourhood of the first click.
module generate_mine_array #(
    parameter int unsigned MINES_EASY   = 10,
    parameter int unsigned MINES_MEDIUM = 16,
    parameter int unsigned MINES_HARD   = 40,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              level,
    input  logic                    start,
    input  logic [4:0]              first_x,
    input  logic [4:0]              first_y,
    output logic [7:0][7:0]         mine_arr_easy,
    output logic [9:0][9:0]         mine_arr_medium,
    output logic [15:0][15:0]       mine_arr_hard,
    output logic                    ready,
    output logic [5:0]              placed
);

    localparam int unsigned CW    = 5;
    localparam int unsigned PW    = 6;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, CLEAR, PICK, DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [1:0]             lvl_q, lvl_d;
    logic [CW-1:0]          fx_q, fx_d, fy_q, fy_d;
    logic [7:0][7:0]        easy_q, easy_d;
    logic [9:0][9:0]        med_q, med_d;
    logic [15:0][15:0]      hard_q, hard_d;
    logic                   ready_q, ready_d;
    logic [PW-1:0]          placed_q, placed_d;

    logic [CW-1:0]          cx_c, cy_c, size_c;
    logic [PW-1:0]          target_c, placed_inc_c;
    logic                   in_board_c, free_c, first_in_c, excl_c, accept_c, abort_c;

    assign lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign cx_c         = lfsr_q[4:0];
    assign cy_c         = lfsr_q[9:5];
    assign placed_inc_c = placed_q + PW'(1);

    // Board geometry and mine target of the latched level
    always_comb begin
        size_c   = CW'(0);
        target_c = PW'(0);
        free_c   = 1'b0;
        unique case (lvl_q)
            2'd1: begin
                size_c   = CW'(8);
                target_c = PW'(MINES_EASY);
                free_c   = easy_q[cx_c[2:0]][cy_c[2:0]];
            end
            2'd2: begin
                size_c   = CW'(10);
                target_c = PW'(MINES_MEDIUM);
                free_c   = med_q[cx_c[3:0]][cy_c[3:0]];
            end
            2'd3: begin
                size_c   = CW'(16);
                target_c = PW'(MINES_HARD);
                free_c   = hard_q[cx_c[3:0]][cy_c[3:0]];
            end
            default: ;
        endcase
    end

    assign in_board_c = (cx_c < size_c) && (cy_c < size_c);
    assign first_in_c = (fx_q < size_c) && (fy_q < size_c);

`ifdef MINE_SAFE_ZONE_EN
    logic [PW-1:0] dx_c, dy_c;
    logic          near_x_c, near_y_c;
    assign dx_c     = PW'(cx_c) - PW'(fx_q);
    assign dy_c     = PW'(cy_c) - PW'(fy_q);
    assign near_x_c = (dx_c == PW'(0)) || (dx_c == PW'(1)) || (dx_c == '1);
    assign near_y_c = (dy_c == PW'(0)) || (dy_c == PW'(1)) || (dy_c == '1);
    assign excl_c   = first_in_c && near_x_c && near_y_c;
`else
    assign excl_c   = first_in_c && (cx_c == fx_q) && (cy_c == fy_q);
`endif

    // free_c is only meaningful once the candidate is known to be on the board
    assign accept_c = in_board_c && free_c && !excl_c;
    assign abort_c  = (level == 2'd0) ||
                      (((state_q == PICK) || (state_q == DONE)) && (level != lvl_q));

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        easy_d   = easy_q;
        med_d    = med_q;
        hard_d   = hard_q;
        ready_d  = ready_q;
        placed_d = placed_q;
        unique case (state_q)
            IDLE: begin
                if (start && (level != 2'd0)) begin
                    state_d = CLEAR;
                    lvl_d   = level;
                    fx_d    = first_x;
                    fy_d    = first_y;
                end
            end
            CLEAR: begin
                easy_d   = '1;
                med_d    = '1;
                hard_d   = '1;
                placed_d = '0;
                ready_d  = 1'b0;
                state_d  = PICK;
            end
            PICK: begin
                if (accept_c) begin
                    unique case (lvl_q)
                        2'd1:    easy_d[cx_c[2:0]][cy_c[2:0]] = 1'b0;
                        2'd2:    med_d[cx_c[3:0]][cy_c[3:0]]  = 1'b0;
                        2'd3:    hard_d[cx_c[3:0]][cy_c[3:0]] = 1'b0;
                        default: ;
                    endcase
                    placed_d = placed_inc_c;
                    if (placed_inc_c == target_c) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ready_d = 1'b1;
                if (start && (level != 2'd0)) begin
                    state_d = CLEAR;
                    lvl_d   = level;
                    fx_d    = first_x;
                    fy_d    = first_y;
                    ready_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Leaving the game or switching level discards any board
        if (abort_c) begin
            state_d  = IDLE;
            easy_d   = '1;
            med_d    = '1;
            hard_d   = '1;
            ready_d  = 1'b0;
            placed_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            lvl_q    <= 2'd0;
            fx_q     <= '0;
            fy_q     <= '0;
            easy_q   <= '1;
            med_q    <= '1;
            hard_q   <= '1;
            ready_q  <= 1'b0;
            placed_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            lvl_q    <= lvl_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            easy_q   <= easy_d;
            med_q    <= med_d;
            hard_q   <= hard_d;
            ready_q  <= ready_d;
            placed_q <= placed_d;
        end
    end

    assign mine_arr_easy   = easy_q;
    assign mine_arr_medium = med_q;
    assign mine_arr_hard   = hard_q;
    assign ready           = ready_q;
    assign placed          = placed_q;

endmodule
